// File: rtl/cv32e40p_alu_permanent_fault_detector.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_alu_permanent_fault_detector
// Purpose  : Turns per-operation TMR voter mismatch flags into a sticky
//            per-replica permanent-fault vector. Each of the four ALU
//            replicas has its own error counter. The counter is cleared
//            every WINDOW_LEN qualified operations. A replica is marked
//            faulty once its errors within one window reach THRESHOLD.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            valid_i                  one voted ALU operation completes
//            active_alu_i[3:0]        replicas taking part in the vote
//            err_alu_i[3:0]           voter disagreement flag per replica
//            clear_i                  synchronous clear of all state
//            permanent_faulty_alu_o   sticky fault flag per replica
//            fault_event_o            pulse when any fault bit rises
//            uncorrectable_o          pulse when >=2 active replicas erred
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_alu_permanent_fault_detector #(
    parameter int WINDOW_LEN = 256,
    parameter int THRESHOLD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [3:0] active_alu_i,
    input  logic [3:0] err_alu_i,
    input  logic       clear_i,
    output logic [3:0] permanent_faulty_alu_o,
    output logic       fault_event_o,
    output logic       uncorrectable_o
);

    localparam int c_win_w = $clog2(WINDOW_LEN);
    localparam int c_cnt_w = $clog2(THRESHOLD + 1);

    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_thr      = c_cnt_w'(THRESHOLD);
    localparam logic [c_cnt_w-1:0] c_thr_m1   = c_cnt_w'(THRESHOLD - 1);

    logic [c_win_w-1:0] r_win_cnt;
    logic [3:0]         r_fault;
    logic               r_fault_event;
    logic               r_uncorr;

    logic               w_qual;
    logic [3:0]         w_act_err;
    logic [3:0]         w_mask;
    logic [2:0]         w_act_cnt;
    logic [2:0]         w_mask_cnt;
    logic               w_multi;
    logic               w_single;
    logic               w_win_wrap;
    logic [3:0]         w_fault_set;

    assign w_qual     = valid_i & ~clear_i;
    assign w_act_err  = err_alu_i & active_alu_i;
    // Replicas already declared faulty no longer contribute to counting.
    assign w_mask     = w_act_err & ~r_fault;
    assign w_win_wrap = (r_win_cnt == c_win_last);

    always_comb begin
        w_act_cnt  = '0;
        w_mask_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            w_act_cnt  = w_act_cnt  + {2'b00, w_act_err[i]};
            w_mask_cnt = w_mask_cnt + {2'b00, w_mask[i]};
        end
    end

    // Multiple disagreeing replicas (faulty ones included) mean the culprit
    // cannot be identified, so nothing is counted for that operation.
    assign w_multi  = (w_act_cnt >= 3'd2);
    assign w_single = ~w_multi & (w_mask_cnt == 3'd1);

    // Per-replica windowed error counter; the threshold test uses the
    // current operation's error before the window wrap clears the counter.
    for (genvar k = 0; k < 4; k++) begin : g_replica
        logic [c_cnt_w-1:0] r_err_cnt;
        logic               w_hit;

        assign w_hit          = w_qual & w_single & w_mask[k];
        assign w_fault_set[k] = w_hit & (r_err_cnt == c_thr_m1);

        always_ff @(posedge clk) begin
            if (rst || clear_i) begin
                r_err_cnt <= '0;
            end else if (w_qual && w_win_wrap) begin
                r_err_cnt <= '0;
            end else if (w_hit && (r_err_cnt != c_thr)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_win_cnt <= '0;
        end else if (w_qual) begin
            r_win_cnt <= w_win_wrap ? '0 : r_win_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_fault       <= '0;
            r_fault_event <= 1'b0;
            r_uncorr      <= 1'b0;
        end else begin
            // w_fault_set only fires on unmasked (not yet faulty) replicas,
            // so any set bit is a genuine 0->1 transition.
            r_fault       <= r_fault | w_fault_set;
            r_fault_event <= |w_fault_set;
            r_uncorr      <= w_qual & w_multi;
        end
    end

    assign permanent_faulty_alu_o = r_fault;
    assign fault_event_o          = r_fault_event;
    assign uncorrectable_o        = r_uncorr;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_alu_permanent_fault_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_alu_permanent_fault_detector
// Purpose  : Self-checking bench for the ALU permanent fault detector, using
//            a behavioural reference model with WINDOW_LEN=16, THRESHOLD=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_alu_permanent_fault_detector;

    localparam int WIN = 16;
    localparam int THR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [3:0] active_alu_i = 4'b0000;
    logic [3:0] err_alu_i = 4'b0000;
    logic [3:0] permanent_faulty_alu_o;
    logic       fault_event_o;
    logic       uncorrectable_o;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         m_cnt[4];
    int         m_win;
    logic [3:0] m_fault;
    logic       m_evt;
    logic       m_unc;

    cv32e40p_alu_permanent_fault_detector #(
        .WINDOW_LEN(WIN),
        .THRESHOLD (THR)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .valid_i               (valid_i),
        .active_alu_i          (active_alu_i),
        .err_alu_i             (err_alu_i),
        .clear_i               (clear_i),
        .permanent_faulty_alu_o(permanent_faulty_alu_o),
        .fault_event_o         (fault_event_o),
        .uncorrectable_o       (uncorrectable_o)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic r, input logic v, input logic [3:0] a,
                                input logic [3:0] e, input logic c);
        logic [3:0] ae;
        ae    = e & a;
        m_evt = 1'b0;
        m_unc = 1'b0;
        if (r || c) begin
            m_win   = 0;
            m_fault = 4'b0000;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else if (v) begin
            if ($countones(ae) >= 2) begin
                m_unc = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (ae[k] && !m_fault[k]) begin
                        m_cnt[k]++;
                        if (m_cnt[k] == THR) begin
                            m_fault[k] = 1'b1;
                            m_evt      = 1'b1;
                        end
                    end
                end
            end
            m_win++;
            if (m_win == WIN) begin
                m_win = 0;
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            end
        end
    endtask

    // Applies one cycle of inputs; returns 1 ns after the edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] e, input logic c);
        rst          = r;
        valid_i      = v;
        active_alu_i = a;
        err_alu_i    = e;
        clear_i      = c;
        @(posedge clk);
        model_update(r, v, a, e, c);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 4'b1111, 4'($urandom), 1'b0);
        drive(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b0);
        tests++;
        if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset: got fault=%b evt=%b unc=%b, expected all 0",
                     permanent_faulty_alu_o, fault_event_o, uncorrectable_o);
        end
    endtask

    task automatic test_transient();
        int placed;
        logic [3:0] e;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int w = 0; w < 3; w++) begin
            placed = 0;
            for (int i = 0; i < WIN; i++) begin
                if ($urandom_range(0, 3) == 0)
                    drive(1'b0, 1'b0, 4'b0111, 4'b0010, 1'b0);
                e = 4'b0000;
                if ((placed < 3) && (((3 - placed) >= (WIN - i)) || ($urandom_range(0, 4) == 0))) begin
                    e = 4'b0010;
                    placed++;
                end
                e = e | {1'($urandom), 3'b000};
                drive(1'b0, 1'b1, 4'b0111, e, 1'b0);
                tests++;
                if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== {m_fault, m_evt, m_unc}
                    || permanent_faulty_alu_o !== 4'b0000 || fault_event_o !== 1'b0) begin
                    fails++;
                    $display("FAIL transient w%0d op%0d: got fault=%b evt=%b unc=%b, expected fault=%b evt=%b unc=%b",
                             w, i, permanent_faulty_alu_o, fault_event_o, uncorrectable_o, m_fault, m_evt, m_unc);
                end
            end
        end
    endtask

    task automatic test_threshold();
        int pulses;
        logic [3:0] a;
        logic [3:0] e;
        pulses = 0;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < WIN + 8; i++) begin
            a = 4'b0100 | 4'($urandom);
            e = ((i == 2) || (i == 5) || (i == 9) || (i >= 12)) ? 4'b0100 : 4'b0000;
            e = e | (4'($urandom) & ~a);
            drive(1'b0, 1'b1, a, e, 1'b0);
            if (fault_event_o === 1'b1) pulses++;
            tests++;
            if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== {m_fault, m_evt, m_unc}
                || (i == 11 && permanent_faulty_alu_o !== 4'b0000)
                || (i == 12 && (permanent_faulty_alu_o !== 4'b0100 || fault_event_o !== 1'b1))
                || (i > 12 && (permanent_faulty_alu_o !== 4'b0100 || fault_event_o !== 1'b0))) begin
                fails++;
                $display("FAIL threshold op%0d: got fault=%b evt=%b unc=%b, expected fault=%b evt=%b unc=%b",
                         i, permanent_faulty_alu_o, fault_event_o, uncorrectable_o, m_fault, m_evt, m_unc);
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL threshold_pulses: got %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic test_window_boundary();
        logic [3:0] e;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < WIN; i++) begin
            e = ((i == 5) || (i == 9) || (i == 13) || (i == 15)) ? 4'b0001 : 4'b0000;
            drive(1'b0, 1'b1, 4'b1111, e, 1'b0);
            tests++;
            if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== {m_fault, m_evt, m_unc}
                || (i == 15 && permanent_faulty_alu_o !== 4'b0001)) begin
                fails++;
                $display("FAIL window_last op%0d: got fault=%b evt=%b, expected fault=%b evt=%b",
                         i, permanent_faulty_alu_o, fault_event_o, m_fault, m_evt);
            end
        end
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < WIN + 4; i++) begin
            e = ((i == 5) || (i == 9) || (i == 13) || (i >= 16)) ? 4'b0001 : 4'b0000;
            drive(1'b0, 1'b1, 4'b1111, e, 1'b0);
            tests++;
            if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== {m_fault, m_evt, m_unc}
                || (i == 18 && permanent_faulty_alu_o !== 4'b0000)
                || (i == 19 && permanent_faulty_alu_o !== 4'b0001)) begin
                fails++;
                $display("FAIL window_next op%0d: got fault=%b evt=%b, expected fault=%b evt=%b",
                         i, permanent_faulty_alu_o, fault_event_o, m_fault, m_evt);
            end
        end
    endtask

    task automatic test_masking();
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < WIN + 4; i++) begin
            drive(1'b0, 1'b1, (i < WIN) ? 4'b0111 : 4'b1110, 4'b1000, 1'b0);
            tests++;
            if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== {m_fault, m_evt, m_unc}
                || (i == WIN + 2 && permanent_faulty_alu_o !== 4'b0000)
                || (i == WIN + 3 && (permanent_faulty_alu_o !== 4'b1000 || fault_event_o !== 1'b1))) begin
                fails++;
                $display("FAIL masking op%0d: got fault=%b evt=%b, expected fault=%b evt=%b",
                         i, permanent_faulty_alu_o, fault_event_o, m_fault, m_evt);
            end
        end
    endtask

    task automatic test_uncorrectable();
        logic [3:0] e;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < WIN + 3; i++) begin
            case (i)
                0, 2, 3, 16: e = 4'b0001;
                1:           e = 4'b0011;
                17, 18:      e = 4'b0110;
                default:     e = 4'b0000;
            endcase
            drive(1'b0, 1'b1, (i >= 17) ? 4'b0111 : 4'b0011, e, 1'b0);
            tests++;
            if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== {m_fault, m_evt, m_unc}
                || (i == 1 && uncorrectable_o !== 1'b1)
                || (i == 2 && uncorrectable_o !== 1'b0)
                || (i == 16 && permanent_faulty_alu_o !== 4'b0000)
                || (i >= 17 && uncorrectable_o !== 1'b1)) begin
                fails++;
                $display("FAIL uncorrectable op%0d: got fault=%b evt=%b unc=%b, expected fault=%b evt=%b unc=%b",
                         i, permanent_faulty_alu_o, fault_event_o, uncorrectable_o, m_fault, m_evt, m_unc);
            end
        end
    endtask

    task automatic test_clear_reset();
        logic [3:0] e;
        for (int mode = 0; mode < 2; mode++) begin
            drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
            for (int i = 0; i < 8; i++)
                drive(1'b0, 1'b1, 4'b1111, (i < 4) ? 4'b0001 : 4'b0100, 1'b0);
            tests++;
            if (permanent_faulty_alu_o !== 4'b0101) begin
                fails++;
                $display("FAIL clear_setup m%0d: got fault=%b, expected 0101", mode, permanent_faulty_alu_o);
            end
            drive(mode == 1, 1'b1, 4'b1111, 4'b0010, mode == 0);
            tests++;
            if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== 6'b0
                || {m_fault, m_evt, m_unc} !== 6'b0) begin
                fails++;
                $display("FAIL clear_outputs m%0d: got fault=%b evt=%b unc=%b, expected all 0",
                         mode, permanent_faulty_alu_o, fault_event_o, uncorrectable_o);
            end
            for (int i = 0; i < 4; i++) begin
                e = 4'b0010;
                drive(1'b0, 1'b1, 4'b1111, e, 1'b0);
                tests++;
                if ({permanent_faulty_alu_o, fault_event_o} !== {m_fault, m_evt}
                    || (i == 2 && permanent_faulty_alu_o !== 4'b0000)
                    || (i == 3 && permanent_faulty_alu_o !== 4'b0010)) begin
                    fails++;
                    $display("FAIL clear_recount m%0d op%0d: got fault=%b evt=%b, expected fault=%b evt=%b",
                             mode, i, permanent_faulty_alu_o, fault_event_o, m_fault, m_evt);
                end
            end
        end
    endtask

    task automatic test_random();
        logic r;
        logic c;
        logic v;
        logic [3:0] a;
        logic [3:0] e;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = 4'($urandom);
            if ($urandom_range(0, 3) == 0) e = 4'($urandom);
            else if ($urandom_range(0, 1) == 0) e = 4'(1 << $urandom_range(0, 3));
            else e = 4'b0000;
            drive(r, v, a, e, c);
            tests++;
            if ({permanent_faulty_alu_o, fault_event_o, uncorrectable_o} !== {m_fault, m_evt, m_unc}) begin
                fails++;
                $display("FAIL random op%0d: got fault=%b evt=%b unc=%b, expected fault=%b evt=%b unc=%b",
                         i, permanent_faulty_alu_o, fault_event_o, uncorrectable_o, m_fault, m_evt, m_unc);
            end
        end
    endtask

    initial begin
        m_win   = 0;
        m_fault = 4'b0000;
        m_evt   = 1'b0;
        m_unc   = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        #2;
        test_reset();
        test_transient();
        test_threshold();
        test_window_boundary();
        test_masking();
        test_uncorrectable();
        test_clear_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
